capture_position_gen: RTL and testbench

Capture-side timing recovery for the line buffer, running in the capture pixel clock domain. Recovers horizontal and vertical position from incoming sync, detects interlace field, and emits the write address (xpos/ypos), write enable and pixel data that feed the dual-clock line buffer. Also produces the frame_change level that the output-side timing generator resynchronises to.

---
 rtl/capture_position_gen_if.sv | 39 +++
 rtl/capture_position_gen.sv | 211 +++++++++++++++++++++
 tb/tb_capture_position_gen.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/capture_position_gen_if.sv
// Capture-side video bus: raw sync/RGB and geometry words in, line buffer
// write address, data and timing status out.
interface capture_position_gen_if;
    logic [7:0]  R_i;
    logic [7:0]  G_i;
    logic [7:0]  B_i;
    logic        HSYNC_i;
    logic        VSYNC_i;
    logic [31:0] h_in_config;
    logic [31:0] h_in_config2;
    logic [31:0] v_in_config;
    logic [31:0] v_in_config2;

    logic [7:0]  R_o;
    logic [7:0]  G_o;
    logic [7:0]  B_o;
    logic        DE_o;
    logic [10:0] xpos_o;
    logic [10:0] ypos_o;
    logic        FID_o;
    logic        frame_change_o;
    logic [11:0] h_total_o;
    logic [10:0] v_total_o;
    logic        sync_lost_o;

    modport master (
        output R_i, G_i, B_i, HSYNC_i, VSYNC_i,
        output h_in_config, h_in_config2, v_in_config, v_in_config2,
        input  R_o, G_o, B_o, DE_o, xpos_o, ypos_o, FID_o, frame_change_o,
        input  h_total_o, v_total_o, sync_lost_o
    );

    modport slave (
        input  R_i, G_i, B_i, HSYNC_i, VSYNC_i,
        input  h_in_config, h_in_config2, v_in_config, v_in_config2,
        output R_o, G_o, B_o, DE_o, xpos_o, ypos_o, FID_o, frame_change_o,
        output h_total_o, v_total_o, sync_lost_o
    );
endinterface

// File: rtl/capture_position_gen.sv
// Capture timing recovery: sync-driven h/v counters, field ID, active window and
// line buffer write address. Define CAPTURE_MEAS_EN for line/frame measurement.
module capture_position_gen (
    input  logic                         PCLK_CAP_i,
    input  logic                         reset_n,
    capture_position_gen_if.slave        vid
);

    localparam logic [11:0] H_SAT = 12'hFFF;
    localparam logic [10:0] V_SAT = 11'h7FF;

    logic [8:0]  h_synclen;
    logic [8:0]  h_backporch;
    logic [10:0] h_active;
    logic [11:0] h_total_cfg;
    logic [4:0]  v_synclen;
    logic [8:0]  v_backporch;
    logic [10:0] v_active;
    logic [10:0] v_fchg;

    assign h_synclen   = vid.h_in_config[28:20];
    assign h_backporch = vid.h_in_config[19:11];
    assign h_active    = vid.h_in_config[10:0];
    assign h_total_cfg = vid.h_in_config2[11:0];
    assign v_synclen   = vid.v_in_config[24:20];
    assign v_backporch = vid.v_in_config[19:11];
    assign v_active    = vid.v_in_config[10:0];
    assign v_fchg      = vid.v_in_config2[10:0];

    logic       hs_s1, vs_s1, hs_s2, vs_s2;
    logic [7:0] r_s1, g_s1, b_s1;
    logic [7:0] r_s2, g_s2, b_s2;

    // Sync stages reset low so a sync already low at reset release is not an edge.
    always_ff @(posedge PCLK_CAP_i or negedge reset_n) begin
        if (!reset_n) begin
            hs_s1 <= 1'b0;
            vs_s1 <= 1'b0;
            hs_s2 <= 1'b0;
            vs_s2 <= 1'b0;
            r_s1  <= 8'd0;
            g_s1  <= 8'd0;
            b_s1  <= 8'd0;
            r_s2  <= 8'd0;
            g_s2  <= 8'd0;
            b_s2  <= 8'd0;
        end else begin
            hs_s1 <= vid.HSYNC_i;
            vs_s1 <= vid.VSYNC_i;
            hs_s2 <= hs_s1;
            vs_s2 <= vs_s1;
            r_s1  <= vid.R_i;
            g_s1  <= vid.G_i;
            b_s1  <= vid.B_i;
            r_s2  <= r_s1;
            g_s2  <= g_s1;
            b_s2  <= b_s1;
        end
    end

    logic hs_edge, vs_edge;
    assign hs_edge = hs_s2 & ~hs_s1;
    assign vs_edge = vs_s2 & ~vs_s1;

    logic [11:0] h_cnt, h_next;
    logic [10:0] v_cnt, v_next;
    logic        vs_pending, pending_next;
    logic        v_wrap;

    always_comb begin
        h_next       = h_cnt;
        v_next       = v_cnt;
        pending_next = vs_pending;
        v_wrap       = 1'b0;
        if (hs_edge) begin
            h_next = 12'd0;
        end else if (h_cnt != H_SAT) begin
            h_next = h_cnt + 12'd1;
        end
        if (hs_edge && (vs_edge || vs_pending)) begin
            v_next       = 11'd0;
            pending_next = 1'b0;
            v_wrap       = 1'b1;
        end else if (hs_edge) begin
            if (v_cnt != V_SAT) begin
                v_next = v_cnt + 11'd1;
            end
        end else if (vs_edge) begin
            pending_next = 1'b1;
        end
    end

    always_ff @(posedge PCLK_CAP_i or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt      <= H_SAT;
            v_cnt      <= V_SAT;
            vs_pending <= 1'b0;
        end else begin
            h_cnt      <= h_next;
            v_cnt      <= v_next;
            vs_pending <= pending_next;
        end
    end

    // Field is judged on the horizontal position of the pixel carrying the vsync edge.
    logic fid_q;
    always_ff @(posedge PCLK_CAP_i or negedge reset_n) begin
        if (!reset_n) begin
            fid_q <= 1'b0;
        end else if (vs_edge) begin
            fid_q <= (h_next >= {1'b0, h_total_cfg[11:1]});
        end
    end

    logic [11:0] h_start;
    logic [12:0] h_end;
    logic [10:0] v_start;
    logic [11:0] v_end;
    logic        h_in, v_in;
    logic [11:0] x_diff;
    logic [10:0] y_diff;

    assign h_start = 12'(h_synclen) + 12'(h_backporch);
    assign h_end   = 13'(h_start) + 13'(h_active);
    assign v_start = 11'(v_synclen) + 11'(v_backporch);
    assign v_end   = 12'(v_start) + 12'(v_active);
    assign h_in    = (h_cnt >= h_start) && (13'(h_cnt) < h_end);
    assign v_in    = (v_cnt >= v_start) && (12'(v_cnt) < v_end);
    assign x_diff  = h_cnt - h_start;
    assign y_diff  = v_cnt - v_start;

    logic [7:0]  r_q, g_q, b_q;
    logic        de_q, fchg_q;
    logic [10:0] xpos_q, ypos_q;

    always_ff @(posedge PCLK_CAP_i or negedge reset_n) begin
        if (!reset_n) begin
            r_q    <= 8'd0;
            g_q    <= 8'd0;
            b_q    <= 8'd0;
            de_q   <= 1'b0;
            xpos_q <= 11'd0;
            ypos_q <= 11'd0;
            fchg_q <= 1'b0;
        end else begin
            r_q    <= r_s2;
            g_q    <= g_s2;
            b_q    <= b_s2;
            de_q   <= h_in && v_in;
            xpos_q <= (h_in && v_in) ? x_diff[10:0] : 11'd0;
            ypos_q <= v_in ? y_diff : 11'd0;
            fchg_q <= (v_cnt == v_fchg);
        end
    end

    assign vid.R_o            = r_q;
    assign vid.G_o            = g_q;
    assign vid.B_o            = b_q;
    assign vid.DE_o           = de_q;
    assign vid.xpos_o         = xpos_q;
    assign vid.ypos_o         = ypos_q;
    assign vid.FID_o          = fid_q;
    assign vid.frame_change_o = fchg_q;

`ifdef CAPTURE_MEAS_EN
    logic [11:0] h_total_q;
    logic [10:0] v_total_q;
    logic        sync_lost_q;
    logic        vs_seen;

    // Lock is regained on the first line start that follows a vsync edge.
    always_ff @(posedge PCLK_CAP_i or negedge reset_n) begin
        if (!reset_n) begin
            h_total_q   <= 12'd0;
            v_total_q   <= 11'd0;
            sync_lost_q <= 1'b1;
            vs_seen     <= 1'b0;
        end else begin
            if (hs_edge) begin
                h_total_q <= (h_cnt == H_SAT) ? h_cnt : h_cnt + 12'd1;
            end
            if (v_wrap) begin
                v_total_q <= (v_cnt == V_SAT) ? v_cnt : v_cnt + 11'd1;
            end
            if (hs_edge) begin
                vs_seen <= 1'b0;
            end else if (vs_edge) begin
                vs_seen <= 1'b1;
            end
            if ((h_next == H_SAT) || (v_next == V_SAT)) begin
                sync_lost_q <= 1'b1;
            end else if (hs_edge && (vs_seen || vs_edge)) begin
                sync_lost_q <= 1'b0;
            end
        end
    end

    assign vid.h_total_o   = h_total_q;
    assign vid.v_total_o   = v_total_q;
    assign vid.sync_lost_o = sync_lost_q;
`else
    assign vid.h_total_o   = 12'd0;
    assign vid.v_total_o   = 11'd0;
    assign vid.sync_lost_o = 1'b0;
`endif

    logic unused_cfg;
    assign unused_cfg = ^{vid.h_in_config[31:29], vid.h_in_config2[31:12],
                          vid.v_in_config[31:25], vid.v_in_config2[31:11], x_diff[11]};

endmodule

// File: tb/tb_capture_position_gen.sv
// Directed bench for capture_position_gen on a small 40x14 raster with a
// 20x6 active window starting at pixel 10, line 5.
module tb_capture_position_gen;

    localparam int HT     = 40;
    localparam int HS     = 4;
    localparam int HBP    = 6;
    localparam int HACT   = 20;
    localparam int VT     = 14;
    localparam int VS     = 2;
    localparam int VBP    = 3;
    localparam int VACT   = 6;
    localparam int VFC    = 2;
    localparam int HSTART = HS + HBP;
    localparam int VSTART = VS + VBP;

`ifdef CAPTURE_MEAS_EN
    localparam bit MEAS = 1'b1;
`else
    localparam bit MEAS = 1'b0;
`endif

    typedef struct {
        bit          v;
        logic [7:0]  r;
        logic [7:0]  g;
        logic [7:0]  b;
        logic        de;
        logic [10:0] x;
        logic [10:0] y;
        logic        fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    bit   lost = 1'b1;
    int   frame_no = 0;
    int   de_cnt = 0;
    int   fc_cnt = 0;
    exp_t pipe [3];

    capture_position_gen_if vid ();

    capture_position_gen dut (
        .PCLK_CAP_i (clk),
        .reset_n    (rst_n),
        .vid        (vid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk_exp(input bit v, input logic [7:0] r, input logic [7:0] g,
                                    input logic [7:0] b, input int l, input int p, input bit pos);
        exp_t e;
        bit inv, inh;
        e.v  = v;
        e.r  = r;
        e.g  = g;
        e.b  = b;
        e.de = 1'b0;
        e.x  = 11'd0;
        e.y  = 11'd0;
        e.fc = 1'b0;
        if (pos) begin
            inv  = (l >= VSTART) && (l < VSTART + VACT);
            inh  = (p >= HSTART) && (p < HSTART + HACT);
            e.de = inv && inh;
            e.x  = (inv && inh) ? 11'(p - HSTART) : 11'd0;
            e.y  = inv ? 11'(l - VSTART) : 11'd0;
            e.fc = (l == VFC);
        end
        return e;
    endfunction

    // Outputs observed now belong to the pixel driven three ticks earlier.
    task automatic tick(input logic hs, input logic vs, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input exp_t e);
        vid.HSYNC_i = hs;
        vid.VSYNC_i = vs;
        vid.R_i     = r;
        vid.G_i     = g;
        vid.B_i     = b;
        @(posedge clk);
        #1;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = e;
        if (pipe[2].v) begin
            check("R_o",    32'(vid.R_o), 32'(pipe[2].r));
            check("G_o",    32'(vid.G_o), 32'(pipe[2].g));
            check("B_o",    32'(vid.B_o), 32'(pipe[2].b));
            check("DE_o",   32'(vid.DE_o), 32'(pipe[2].de));
            check("xpos_o", 32'(vid.xpos_o), 32'(pipe[2].x));
            check("ypos_o", 32'(vid.ypos_o), 32'(pipe[2].y));
            check("fchg_o", 32'(vid.frame_change_o), 32'(pipe[2].fc));
        end
        de_cnt += int'(vid.DE_o);
        fc_cnt += int'(vid.frame_change_o);
    endtask

    task automatic drive_frame(input int ht, input int vs_pix, input bit chk, input int rst_at);
        int hold;
        hold   = 0;
        de_cnt = 0;
        fc_cnt = 0;
        for (int l = 0; l < VT; l++) begin
            for (int p = 0; p < ht; p++) begin
                int   n;
                logic hs, vs;
                exp_t e;
                n  = l * ht + p;
                hs = (p >= HS);
                vs = !((n >= vs_pix) && (n < vs_pix + VS * ht));
                if (n == rst_at) begin
                    check("de_before_rst",   32'(vid.DE_o), 32'd1);
                    check("xpos_before_rst", 32'(vid.xpos_o), 32'd2);
                    check("ypos_before_rst", 32'(vid.ypos_o), 32'd2);
                    rst_n = 1'b0;
                    #1;
                    check("de_at_rst",   32'(vid.DE_o), 32'd0);
                    check("xpos_at_rst", 32'(vid.xpos_o), 32'd0);
                    check("ypos_at_rst", 32'(vid.ypos_o), 32'd0);
                    check("R_at_rst",    32'(vid.R_o), 32'd0);
                    check("fchg_at_rst", 32'(vid.frame_change_o), 32'd0);
                    check("lost_at_rst", 32'(vid.sync_lost_o), 32'(MEAS));
                    for (int i = 0; i < 3; i++) pipe[i] = mk_exp(1'b1, 8'd0, 8'd0, 8'd0, 0, 0, 1'b0);
                    lost = 1'b1;
                    hold = 3;
                end
                if (hold > 0) e = mk_exp(chk, 8'd0, 8'd0, 8'd0, l, p, 1'b0);
                else          e = mk_exp(chk, 8'(p), 8'(l), 8'(frame_no), l, p, !lost);
                tick(hs, vs, 8'(p), 8'(l), 8'(frame_no), e);
                if (hold > 0) begin
                    hold--;
                    if (hold == 0) rst_n = 1'b1;
                end
            end
        end
        if (chk && rst_at < 0) begin
            check("de_per_frame",   32'(de_cnt), 32'(HACT * VACT));
            check("fchg_per_frame", 32'(fc_cnt), 32'(ht));
        end
        frame_no++;
    endtask

    initial begin
        vid.R_i          = 8'd0;
        vid.G_i          = 8'd0;
        vid.B_i          = 8'd0;
        vid.HSYNC_i      = 1'b1;
        vid.VSYNC_i      = 1'b1;
        vid.h_in_config  = {3'd0, 9'(HS), 9'(HBP), 11'(HACT)};
        vid.h_in_config2 = 32'(HT);
        vid.v_in_config  = {7'd0, 5'(VS), 9'(VBP), 11'(VACT)};
        vid.v_in_config2 = 32'(VFC);
        for (int i = 0; i < 3; i++) pipe[i] = mk_exp(1'b1, 8'd0, 8'd0, 8'd0, 0, 0, 1'b0);

        // Activity on the pins while held in reset must not reach the outputs.
        for (int i = 0; i < 8; i++) begin
            tick(1'(i % 2), 1'(i / 2 % 2), 8'(i * 3 + 1), 8'hA5, 8'h5A,
                 mk_exp(1'b1, 8'd0, 8'd0, 8'd0, 0, 0, 1'b0));
        end
        check("fid_rst",     32'(vid.FID_o), 32'd0);
        check("htotal_rst",  32'(vid.h_total_o), 32'd0);
        check("vtotal_rst",  32'(vid.v_total_o), 32'd0);
        check("lost_rst",    32'(vid.sync_lost_o), 32'(MEAS));
        rst_n = 1'b1;

        // Hsync only: no vertical lock, so no DE/positions.
        for (int l = 0; l < 3; l++) begin
            for (int p = 0; p < HT; p++) begin
                tick(1'(p >= HS), 1'b1, 8'(p), 8'hEE, 8'(l),
                     mk_exp(1'b1, 8'(p), 8'hEE, 8'(l), 0, 0, 1'b0));
            end
        end
        check("lost_prelock", 32'(vid.sync_lost_o), 32'(MEAS));

        lost = 1'b0;
        drive_frame(HT, 0, 1'b1, -1);
        drive_frame(HT, 0, 1'b1, -1);
        check("htotal_40",  32'(vid.h_total_o), MEAS ? 32'd40 : 32'd0);
        check("vtotal_14",  32'(vid.v_total_o), MEAS ? 32'd14 : 32'd0);
        check("lost_locked", 32'(vid.sync_lost_o), 32'd0);
        check("fid_prog",   32'(vid.FID_o), 32'd0);

        drive_frame(HT, 20, 1'b0, -1);
        check("fid_half",   32'(vid.FID_o), 32'd1);
        drive_frame(HT, 19, 1'b0, -1);
        check("fid_below",  32'(vid.FID_o), 32'd0);
        drive_frame(HT, 20, 1'b0, -1);
        check("fid_toggle", 32'(vid.FID_o), 32'd1);
        drive_frame(HT, 0, 1'b1, -1);
        check("fid_aligned", 32'(vid.FID_o), 32'd0);

        drive_frame(44, 0, 1'b1, -1);
        check("htotal_44", 32'(vid.h_total_o), MEAS ? 32'd44 : 32'd0);

        for (int i = 0; i < 4100; i++) begin
            tick(1'b1, 1'b1, 8'(i), 8'h33, 8'h44, mk_exp(1'b1, 8'(i), 8'h33, 8'h44, 0, 0, 1'b0));
        end
        check("lost_nosync", 32'(vid.sync_lost_o), 32'(MEAS));
        drive_frame(HT, 0, 1'b1, -1);
        check("lost_relock", 32'(vid.sync_lost_o), 32'd0);

        drive_frame(HT, 0, 1'b1, 7 * HT + 15);
        check("fid_after_rst", 32'(vid.FID_o), 32'd0);
        lost = 1'b0;
        drive_frame(HT, 0, 1'b1, -1);
        check("lost_after_rst", 32'(vid.sync_lost_o), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
